// File: rtl/mem_arbiter_pkg.sv
// Shared constants, state encoding and lane helper for the instruction/data
// memory arbiter.
package mem_arbiter_pkg;

  localparam int XLEN         = 64;
  localparam int ILEN         = 32;
  localparam int WD_W         = 8;
  localparam int WATCHDOG_MAX = 255;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUS_IF  = 2'd1,
    BUS_MEM = 2'd2,
    DROP    = 2'd3
  } arb_state_e;

  // Fetches are 4-byte aligned, so address bit 2 selects the 32-bit half.
  function automatic logic [ILEN-1:0] fetch_lane(input logic [XLEN-1:0] rdata,
                                                 input logic            hi);
    return hi ? rdata[XLEN-1:ILEN] : rdata[ILEN-1:0];
  endfunction

endpackage

// File: rtl/mem_arbiter_watchdog.sv
// Bus watchdog: counts cycles a request waits for ack; flags a timeout at the
// terminal count unless the ack arrives in that same cycle.
import mem_arbiter_pkg::*;

module bus_watchdog (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  input  logic ack,
  output logic timeout
);

  logic [WD_W-1:0] count;
  logic            at_max;

  assign at_max  = (count == WD_W'(WATCHDOG_MAX));
  assign timeout = enable & ~ack & at_max;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !ack && !at_max) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates a single shared memory port between instruction fetch and data
// accesses, one outstanding transaction at a time, with a watchdog timeout.
import mem_arbiter_pkg::*;

// state   | meaning
// IDLE    | no transaction outstanding, may grant
// BUS_IF  | fetch on the bus, waiting for ack
// BUS_MEM | load/store on the bus, waiting for ack
// DROP    | flushed fetch still on the bus, ack is discarded
module mem_arbiter (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_req,
  input  logic [XLEN-1:0] if_addr,
  input  logic            if_flush,
  output logic            if_ready,
  output logic [ILEN-1:0] if_rdata,
  input  logic            mem_req,
  input  logic            mem_we,
  input  logic [XLEN-1:0] mem_addr,
  input  logic [XLEN-1:0] mem_wdata,
  input  logic [7:0]      mem_wmask,
  output logic            mem_ready,
  output logic [XLEN-1:0] mem_rdata,
  output logic            bus_valid,
  output logic            bus_we,
  output logic [XLEN-1:0] bus_addr,
  output logic [XLEN-1:0] bus_wdata,
  output logic [7:0]      bus_wmask,
  input  logic            bus_ack,
  input  logic [XLEN-1:0] bus_rdata,
  output logic            stall_if,
  output logic            stall_mem,
  output logic            bus_err
);

  arb_state_e state;
  logic       grant_mem;
  logic       grant_if;
  logic       timeout;

  // A requester whose ready is pulsing still holds req this cycle; it must not
  // be granted again.
  assign grant_mem = (state == IDLE) & mem_req & ~mem_ready;
  assign grant_if  = (state == IDLE) & ~grant_mem & if_req & ~if_flush & ~if_ready;

  assign stall_if  = if_req & ~if_ready;
  assign stall_mem = mem_req & ~mem_ready;

  bus_watchdog u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .clear   (grant_mem | grant_if),
    .enable  (bus_valid),
    .ack     (bus_ack),
    .timeout (timeout)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      bus_valid <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_wdata <= '0;
      bus_wmask <= '0;
      if_ready  <= 1'b0;
      if_rdata  <= '0;
      mem_ready <= 1'b0;
      mem_rdata <= '0;
      bus_err   <= 1'b0;
    end else begin
      if_ready  <= 1'b0;
      mem_ready <= 1'b0;
      bus_err   <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_mem) begin
            bus_valid <= 1'b1;
            bus_we    <= mem_we;
            bus_addr  <= mem_addr;
            bus_wdata <= mem_wdata;
            bus_wmask <= mem_wmask;
            state     <= BUS_MEM;
          end else if (grant_if) begin
            bus_valid <= 1'b1;
            bus_we    <= 1'b0;
            bus_addr  <= if_addr;
            bus_wdata <= '0;
            bus_wmask <= '0;
            state     <= BUS_IF;
          end
        end
        BUS_IF: begin
          if (if_flush) begin
            // A redirect cancels delivery even if the ack lands this cycle.
            if (bus_ack || timeout) begin
              bus_valid <= 1'b0;
              bus_err   <= timeout;
              state     <= IDLE;
            end else begin
              state <= DROP;
            end
          end else if (bus_ack) begin
            bus_valid <= 1'b0;
            if_ready  <= 1'b1;
            if_rdata  <= fetch_lane(bus_rdata, bus_addr[2]);
            state     <= IDLE;
          end else if (timeout) begin
            bus_valid <= 1'b0;
            bus_err   <= 1'b1;
            if_ready  <= 1'b1;
            if_rdata  <= '0;
            state     <= IDLE;
          end
        end
        BUS_MEM: begin
          if (bus_ack) begin
            bus_valid <= 1'b0;
            mem_ready <= 1'b1;
            mem_rdata <= bus_we ? '0 : bus_rdata;
            state     <= IDLE;
          end else if (timeout) begin
            bus_valid <= 1'b0;
            bus_err   <= 1'b1;
            mem_ready <= 1'b1;
            mem_rdata <= '0;
            state     <= IDLE;
          end
        end
        DROP: begin
          if (bus_ack || timeout) begin
            bus_valid <= 1'b0;
            bus_err   <= timeout;
            state     <= IDLE;
          end
        end
        default: begin
          bus_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule
